alu_share_ctrl: RTL and testbench

- Round-robin controller that shares one combinational 16-bit ALU adder among NREQ requesters.
- The ALU is instantiated beside this block. The controller drives the ALU operands (X, Y) and captures the sum Z and the flags S, ZR, CY, P, V.
- Each requester uses valid/ready on the request side and valid/ready on the response side.
- Also keeps a wrapping count of completed operations for debug.

---
 rtl/alu_share_pkg.sv | 21 ++
 rtl/alu_share_ctrl_rr_pick.sv | 31 +++
 rtl/alu_share_ctrl.sv | 107 ++++++++++
 tb/tb_alu_share_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// Shared types and constants for the round-robin ALU-sharing controller.
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Bit positions inside the packed {S,ZR,CY,P,V} flag vector.
    localparam int FLG_S  = 4;
    localparam int FLG_ZR = 3;
    localparam int FLG_CY = 2;
    localparam int FLG_P  = 1;
    localparam int FLG_V  = 0;
    localparam int NFLG   = 5;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 16;

endpackage

// File: rtl/alu_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_i, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    logic [IDXW-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the search so no path can infer a latch.
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDXW'((int'(last_i) + off) % NREQ);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one external combinational ALU adder among NREQ
// requesters, with valid/ready request and response channels.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic [NREQ-1:0]  req_ready,
    output logic [W-1:0]     alu_x,
    output logic [W-1:0]     alu_y,
    input  logic [W-1:0]     alu_z,
    input  logic [NFLG-1:0]  alu_flags,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [W-1:0]     rsp_data,
    output logic [NFLG-1:0]  rsp_flags,
    input  logic [NREQ-1:0]  rsp_ready,
    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int IDXW = $clog2(NREQ);

    state_t          state_q;
    logic [IDXW-1:0] last_grant_q;
    logic [IDXW-1:0] grant_q;
    logic [W-1:0]    alu_x_q;
    logic [W-1:0]    alu_y_q;
    logic [W-1:0]    rsp_data_q;
    logic [NFLG-1:0] rsp_flags_q;
    logic [15:0]     op_count_q;
    logic [15:0]     op_count_d;

    logic [NREQ-1:0] pick_grant;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;
    logic            rsp_done;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i   (req_valid),
        .last_i  (last_grant_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Handshake outputs are decoded from state so they are all low right after reset.
    assign req_ready = (state_q == IDLE) ? pick_grant : '0;
    assign rsp_valid = (state_q == RESP) ? (NREQ'(1) << grant_q) : '0;
    assign busy      = (state_q != IDLE);
    assign rsp_done  = (state_q == RESP) && rsp_ready[grant_q];

    assign op_count_d = op_count_q + 16'(rsp_done);

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDXW'(NREQ - 1);
            grant_q      <= '0;
            alu_x_q      <= '0;
            alu_y_q      <= '0;
            rsp_data_q   <= '0;
            rsp_flags_q  <= '0;
            op_count_q   <= '0;
        end else begin
            op_count_q <= op_count_d;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        alu_x_q <= req_x[int'(pick_idx)*W +: W];
                        alu_y_q <= req_y[int'(pick_idx)*W +: W];
                        grant_q <= pick_idx;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_z;
                    rsp_flags_q <= alu_flags;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        last_grant_q <= grant_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU and a response scoreboard.
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      alu_x;
    logic [W-1:0]      alu_y;
    logic [W-1:0]      alu_z;
    logic [NFLG-1:0]   alu_flags;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic [NFLG-1:0]   rsp_flags;
    logic [NREQ-1:0]   rsp_ready;
    logic              busy;
    logic [15:0]       op_count;

    typedef struct {
        int              idx;
        logic [W-1:0]    data;
        logic [NFLG-1:0] flags;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_count = '0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_z     (alu_z),
        .alu_flags (alu_flags),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .op_count  (op_count)
    );

    // Behavioural ALU beside the controller; P is even parity of the sum.
    logic [W:0] alu_sum;
    assign alu_sum   = {1'b0, alu_x} + {1'b0, alu_y};
    assign alu_z     = alu_sum[W-1:0];
    assign alu_flags = {alu_sum[W-1], ~|alu_sum[W-1:0], alu_sum[W], ~^alu_sum[W-1:0],
                        (alu_x[W-1] == alu_y[W-1]) && (alu_sum[W-1] != alu_x[W-1])};

    function automatic exp_t model(input int idx, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        m;
        int          us;
        int          ss;
        logic [15:0] z;
        us = int'(x) + int'(y);
        ss = int'($signed(x)) + int'($signed(y));
        z  = us[15:0];
        m.idx   = idx;
        m.data  = z;
        m.flags = '0;
        m.flags[FLG_S]  = z[15];
        m.flags[FLG_ZR] = (z == 16'h0000);
        m.flags[FLG_CY] = (us > 65535);
        m.flags[FLG_P]  = ($countones(z) % 2 == 0);
        m.flags[FLG_V]  = (ss > 32767) || (ss < -32768);
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_op_count"}, 32'(op_count), 32'(exp_count));
    endtask

    // Offers one request alone; leaves the bench at the negedge inside EXEC.
    task automatic launch(input int idx, input logic [W-1:0] x, input logic [W-1:0] y);
        req_valid           = NREQ'(1) << idx;
        req_x[idx*W +: W]   = x;
        req_y[idx*W +: W]   = y;
        #1;
        check("req_ready", 32'(req_ready), 32'(NREQ'(1) << idx));
        sb_q.push_back(model(idx, x, y));
        @(negedge clk);
        req_valid = '0;
        #1;
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_alu_x", 32'(alu_x), 32'(x));
        check("exec_alu_y", 32'(alu_y), 32'(y));
    endtask

    // Waits (bounded) for the next response and compares it with the scoreboard head.
    task automatic expect_rsp(output logic [W-1:0] d, output logic [NFLG-1:0] f);
        int   waited = 0;
        exp_t e;
        do begin
            @(negedge clk);
            #1;
            waited++;
        end while (rsp_valid == '0 && waited < 8);
        check("rsp_latency", 32'(waited), 32'd1);
        d = rsp_data;
        f = rsp_flags;
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << e.idx));
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]    d;
        logic [NFLG-1:0] f;
        logic [W-1:0]    held_d;
        logic [NFLG-1:0] held_f;
        logic [W-1:0]    rr_x [NREQ];
        logic [W-1:0]    rr_y [NREQ];

        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        // Reset state.
        check_idle("reset");
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_alu_x", 32'(alu_x), 32'd0);
        check("reset_alu_y", 32'(alu_y), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_rsp_flags", 32'(rsp_flags), 32'd0);

        // Single add on requester 0 with carry and signed overflow.
        rsp_ready = '1;
        launch(0, 16'h8FFF, 16'h8000);
        expect_rsp(d, f);
        check("t1_data", 32'(d), 32'h0FFF);
        check("t1_cy", 32'(f[FLG_CY]), 32'd1);
        check("t1_v", 32'(f[FLG_V]), 32'd1);
        check("t1_s", 32'(f[FLG_S]), 32'd0);
        check("t1_zr", 32'(f[FLG_ZR]), 32'd0);
        @(negedge clk);
        #1;
        exp_count++;
        check_idle("t1_done");

        // Zero result on requester 1.
        launch(1, 16'hFFFE, 16'h0002);
        expect_rsp(d, f);
        check("t2_valid_only1", 32'(rsp_valid), 32'h2);
        check("t2_data", 32'(d), 32'h0000);
        check("t2_zr", 32'(f[FLG_ZR]), 32'd1);
        check("t2_cy", 32'(f[FLG_CY]), 32'd1);
        check("t2_v", 32'(f[FLG_V]), 32'd0);
        check("t2_s", 32'(f[FLG_S]), 32'd0);
        @(negedge clk);
        #1;
        exp_count++;
        check_idle("t2_done");

        // Back-pressure on requester 0; the other rsp_ready bits must be ignored.
        rsp_ready = 4'b1110;
        launch(0, 16'h1234, 16'h4321);
        expect_rsp(held_d, held_f);
        req_valid = 4'b1110;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rsp_data", 32'(rsp_data), 32'(held_d));
            check("bp_rsp_flags", 32'(rsp_flags), 32'(held_f));
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_op_count", 32'(op_count), 32'(exp_count));
        end
        req_valid = '0;
        rsp_ready = 4'b0001;
        @(negedge clk);
        #1;
        exp_count++;
        check_idle("bp_release");

        // Reset during EXEC drops the transaction.
        rsp_ready = '1;
        launch(2, 16'h0100, 16'h0200);
        void'(sb_q.pop_back());
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_count = '0;
        check_idle("midrst");
        check("midrst_alu_x", 32'(alu_x), 32'd0);
        check("midrst_rsp_data", 32'(rsp_data), 32'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Round robin with all requesters continuously valid.
        rr_x[0] = 16'h0001; rr_y[0] = 16'h0002;
        rr_x[1] = 16'h7FFF; rr_y[1] = 16'h0001;
        rr_x[2] = 16'hAAAA; rr_y[2] = 16'h5555;
        rr_x[3] = 16'hFFFF; rr_y[3] = 16'hFFFF;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*W +: W] = rr_x[i];
            req_y[i*W +: W] = rr_y[i];
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_grant", 32'(req_ready), 32'(NREQ'(1) << (k % NREQ)));
            sb_q.push_back(model(k % NREQ, rr_x[k % NREQ], rr_y[k % NREQ]));
            @(negedge clk);
            expect_rsp(d, f);
            if (k == 2) begin
                check("rr_req2_data", 32'(d), 32'hFFFF);
                check("rr_req2_s", 32'(f[FLG_S]), 32'd1);
                check("rr_req2_cy", 32'(f[FLG_CY]), 32'd0);
            end
            @(negedge clk);
            exp_count++;
        end
        req_valid = '0;
        #1;
        check_idle("rr_done");
        check("rr_count5", 32'(op_count), 32'd5);

        // op_count wrap: preload FFFF while a response is held back.
        rsp_ready = '0;
        @(negedge clk);
        launch(3, 16'h0003, 16'h0004);
        expect_rsp(d, f);
        force dut.op_count_d = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_d;
        #1;
        check("wrap_preload", 32'(op_count), 32'h0000FFFF);
        exp_count = 16'hFFFF;
        rsp_ready = '1;
        @(negedge clk);
        #1;
        exp_count++;
        check_idle("wrap");
        check("wrap_zero", 32'(op_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
